// File: rtl/serial_adder_if.sv
// Operand/result bundle between the Tiny Tapeout wrapper and serial_adder.
// The sub select exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell reused over WIDTH cycles.
// Define SERIAL_ADDER_SUB_EN to add the subtract mode (a - b - cin).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  serial_adder_if.slave bus
);
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] psum;
  logic             carry, c_msb_in;
  logic             s_bit, c_bit, last_bit;
  logic [WIDTH-1:0] psum_shift;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  always_comb begin
    {c_bit, s_bit} = full_add(a_sh[0], b_sh[0], carry);
    last_bit       = (cnt == CNT_W'(WIDTH - 1));
    psum_shift     = {s_bit, psum};
  end

  // Subtraction is a + ~b + ~cin, so cin acts as an active-high borrow-in.
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_load = bus.sub ? ~bus.b : bus.b;
    c_load = bus.sub ? ~bus.cin : bus.cin;
  end
`else
  always_comb begin
    b_load = bus.b;
    c_load = bus.cin;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ena) begin
      case (state)
        IDLE:    if (bus.start) state_nxt = RUN;
        RUN:     if (last_bit)  state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      psum     <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            psum  <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          psum  <= psum_shift[WIDTH-1:1];
          carry <= c_bit;
          cnt   <= cnt + CNT_W'(1);
          // c_bit here is the carry that enters the MSB on the final step.
          if (cnt == CNT_W'(WIDTH - 2)) c_msb_in <= c_bit;
          if (last_bit) begin
            bus.sum  <= psum_shift;
            bus.cout <= c_bit;
            bus.ovf  <= c_msb_in ^ c_bit;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded directed test of serial_adder at WIDTH=8.
module tb_serial_adder;
  localparam int W = 8;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every enabled done cycle must match the next queued result.
  always @(negedge clk) begin
    if (rst_n && ena && bus.done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sum", bus.sum, e.s);
        chk("cout", bus.cout, e.c);
        chk("ovf", bus.ovf, e.o);
        chk("done_cycle", cyc, e.t);
      end
    end
  end

  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic tci,
                       input logic tsb, input logic [7:0] es, input logic ec,
                       input logic eo, input int gap, input bit push, output int acc);
    @(negedge clk);
    bus.a     = ta;
    bus.b     = tb_v;
    bus.cin   = tci;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = tsb;
`endif
    bus.start = 1'b1;
    @(posedge clk);
    acc = cyc;
    if (push) q.push_back('{s: es, c: ec, o: eo, t: acc + W + gap + 1});
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
  endtask

  task automatic wait_idle(input int acc, input int gap);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("idle_cycle", cyc, acc + W + gap + 2);
  endtask

  initial begin
    int acc;
    logic [7:0] snap_sum;
    logic snap_cout, snap_ovf;

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Carry wrap and signed overflow cases.
    issue(8'h01, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, acc);
    wait_idle(acc, 0);
    issue(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0, 1'b1, acc);
    wait_idle(acc, 0);
    issue(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 0, 1'b1, acc);
    wait_idle(acc, 0);

    // A start pulse mid-run must be ignored.
    issue(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 0, 1'b1, acc);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(acc, 0);

    // Three-cycle enable gap in RUN: everything holds, latency grows by three.
    issue(8'h3C, 8'h4B, 1'b0, 1'b0, 8'h87, 1'b0, 1'b1, 3, 1'b1, acc);
    @(negedge clk);
    @(negedge clk);
    ena = 1'b0;
    snap_sum  = bus.sum;
    snap_cout = bus.cout;
    snap_ovf  = bus.ovf;
    repeat (3) begin
      @(negedge clk);
      chk("gap_busy", bus.busy, 1);
      chk("gap_done", bus.done, 0);
      chk("gap_sum", bus.sum, snap_sum);
      chk("gap_cout", bus.cout, snap_cout);
      chk("gap_ovf", bus.ovf, snap_ovf);
    end
    ena = 1'b1;
    wait_idle(acc, 3);

    // Asynchronous reset mid-operation, then a clean operation.
    issue(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 0, 1'b0, acc);
    while (cyc < acc + 4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_sum", bus.sum, 0);
    chk("arst_cout", bus.cout, 0);
    chk("arst_ovf", bus.ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, acc);
    wait_idle(acc, 0);

`ifdef SERIAL_ADDER_SUB_EN
    issue(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 0, 1'b1, acc);
    wait_idle(acc, 0);
    issue(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0, 1'b1, acc);
    wait_idle(acc, 0);
`endif

    repeat (3) @(negedge clk);
    chk("results_outstanding", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial ripple adder that reuses a single full-adder cell over WIDTH clock cycles to add two WIDTH-bit operands with carry-in. It is the multi-bit, clocked successor to the team's single-bit full-adder cell. It sits behind the top-level Tiny Tapeout wrapper, fed from `ui_in`/`uio_in` and driving `uo_out`. A start/busy/done handshake lets the wrapper time the carry chain cycle by cycle.

## Interface
Parameters:
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.

Ports:
- `clk`  in  1  system clock; all state on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ena`  in  1  global enable; when low, all state holds.
- `start`  in  1  request; accepted only in IDLE with `ena`=1.
- `a`  in  WIDTH  operand A; sampled on the accepting edge only.
- `b`  in  WIDTH  operand B; sampled on the accepting edge only.
- `cin`  in  1  carry-in; sampled on the accepting edge only.
- `sub`  in  1  subtract select; present only with `SERIAL_ADDER_SUB_EN`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  high for exactly one enabled cycle when a result is ready.
- `sum`  out  WIDTH  result of the last completed operation.
- `cout`  out  1  carry out of the MSB for the last completed operation.
- `ovf`  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states:
  - IDLE: waits for `start`.
  - RUN: processes one bit per cycle.
  - DONE: presents the result.
- IDLE→RUN on an edge with `ena`=1 and `start`=1:
  - Load shift registers A_sh←`a` and B_sh←`b`.
  - Load carry register C←`cin`.
  - Clear the bit counter to 0.
  - Clear the internal partial-sum shift register.
- RUN, each enabled edge:
  - Full adder on A_sh[0], B_sh[0] and C produces s and c.
  - s shifts into the partial-sum MSB, shifting right; A_sh and B_sh shift right.
  - C←c, and the counter increments.
  - On the edge where counter = WIDTH-2, latch C into C_msb_in (the carry into the MSB).
- RUN→DONE on the edge processing bit WIDTH-1:
  - `sum`←final partial sum.
  - `cout`←c.
  - `ovf`←C_msb_in XOR c.
- DONE→IDLE on the next enabled edge.
- `start` in RUN or DONE is ignored; there is no queueing.
- `sum`/`cout`/`ovf` change only on the RUN→DONE edge and hold between operations.
- `ena`=0: FSM, counter, shift registers and outputs all freeze. `done` stays high if frozen in DONE.
- Arithmetic is modulo 2^WIDTH; `cout` is the (WIDTH+1)th bit.

## Timing
- Reset values:
  - State = IDLE.
  - `busy`=0, `done`=0.
  - `sum`=0, `cout`=0, `ovf`=0.
  - All internal registers = 0.
- Latency, with `ena` held high:
  - `start` accepted at edge 0.
  - `busy` high from after edge 0 until after edge WIDTH+1.
  - `done` high in the cycle after edge WIDTH, so WIDTH cycles after acceptance.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accept is edge WIDTH+1, but only in the cycle after DONE has left to IDLE, so the next accept occurs at edge WIDTH+2.
- Each cycle with `ena` low extends latency by one cycle.
- `rst_n` asserted mid-operation: outputs clear immediately, independent of the clock, and the operation is abandoned. The first operation after deassertion completes correctly.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro `SERIAL_ADDER_SUB_EN` defined:
  - The `sub` port exists and is sampled with the operands.
  - `sub`=1 loads B_sh←~`b` and C←~`cin`, computing `a`−`b`−`cin` with `cin` acting as borrow-in.
  - In subtract mode, `cout`=1 means no borrow; `ovf` is signed subtract overflow.
- Macro undefined: no `sub` port, add-only.
- All other behaviour and timing are identical in both builds.

## Test plan
All scenarios use WIDTH=8.
- Carry wrap: a=0x01, b=0xFF, cin=0, start at edge 0. Expect `done` after edge 8 with `sum`=0x00, `cout`=1, `ovf`=0; `busy` low again after edge 9.
- Signed overflow: a=0x7F, b=0x01, cin=0 → `sum`=0x80, `cout`=0, `ovf`=1. Then a=0xFF, b=0xFF, cin=1 → `sum`=0xFF, `cout`=1, `ovf`=0.
- Start ignored: pulse `start` with a=0x00, b=0x00 at edge 3 of a running 0x10+0x20 operation. Expect `sum`=0x30 and exactly one `done` pulse.
- Enable gating: drop `ena` for 3 cycles mid-RUN. Expect `done` 11 cycles after accept with the correct result, and outputs frozen throughout the gap.
- Reset mid-operation: assert `rst_n`=0 at edge 4 of an operation. Expect `busy`, `done`, `sum`, `cout` and `ovf` all 0 immediately; the next 0x55+0xAA, cin=1 → `sum`=0x00, `cout`=1.
- Subtract (`SERIAL_ADDER_SUB_EN` defined): sub=1, a=0x05, b=0x07, cin=0 → `sum`=0xFE, `cout`=0, `ovf`=0. Then a=0x80, b=0x01 → `sum`=0x7F, `ovf`=1.
